// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and RAM geometry for the instruction-memory loader
package imem_loader_pkg;
  localparam int IMEM_DEPTH = 32;
  localparam int IMEM_AW    = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - big-endian byte-to-word shift register with a one-cycle word strobe
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= '0;
      end else if (byte_en) begin
        word       <= {word[23:0], byte_data};
        byte_cnt   <= byte_cnt + 2'd1;
        // strobe lands the cycle after the 4th byte, while word holds it
        word_valid <= (byte_cnt == 2'd3);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the writable instruction RAM
// Frame: LEN byte, LEN*4 payload bytes (MSB first), XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  localparam int NW = AW + 1;

  state_t        state;
  logic [NW-1:0] n_words;
  logic [NW-1:0] idx;
  logic [7:0]    csum;
  logic [1:0]    byte_cnt;
  logic          accept;
  logic          byte_en;

  assign accept  = RxValid & RxReady;
  // a byte arriving alongside Start is dropped
  assign byte_en = accept & (state == S_DATA) & ~Start;

  imem_word_packer u_packer (
    .clk        (Clk),
    .rst        (Reset),
    .clear      (Start),
    .byte_en    (byte_en),
    .byte_data  (RxData),
    .word       (WrData),
    .byte_cnt   (byte_cnt),
    .word_valid (WrEn)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      n_words <= '0;
      idx     <= '0;
      csum    <= '0;
      WrAddr  <= '0;
      RxReady <= 1'b0;
      CpuHold <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else if (Start) begin
      state   <= S_LEN;
      n_words <= '0;
      idx     <= '0;
      csum    <= '0;
      RxReady <= 1'b1;
      CpuHold <= 1'b1;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else begin
      case (state)
        S_LEN: if (accept) begin
          if (RxData == 8'd0) begin
            n_words <= NW'(DEPTH);
            state   <= S_DATA;
          end else if ({1'b0, RxData} > 9'(DEPTH)) begin
            state   <= S_ERROR;
            Error   <= 1'b1;
            CpuHold <= 1'b0;
            RxReady <= 1'b0;
          end else begin
            n_words <= NW'(RxData);
            state   <= S_DATA;
          end
        end
        S_DATA: if (accept) begin
          csum <= csum ^ RxData;
          if (byte_cnt == 2'd3) begin
            WrAddr <= 32'({idx[AW-1:0], 2'b00});
            idx    <= idx + NW'(1);
            if (idx == n_words - NW'(1)) state <= S_CSUM;
          end
        end
        S_CSUM: if (accept) begin
          RxReady <= 1'b0;
          CpuHold <= 1'b0;
          if (RxData == csum) begin
            state <= S_DONE;
            Done  <= 1'b1;
          end else begin
            state <= S_ERROR;
            Error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
